instr_state_encoder: RTL and testbench



---
 rtl/instr_state_encoder_if.sv | 16 +
 rtl/instr_state_encoder.sv | 111 +++++++++++
 tb/tb_instr_state_encoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_state_encoder_if.sv
// Instruction-in / state-code-out bundle for the ARMSIM start-state encoder.
// The master drives instructions; the slave returns the registered state code.
interface instr_state_encoder_if;
    logic [31:0] instr;
    logic [6:0]  state_code;

    modport master (
        output instr,
        input  state_code
    );

    modport slave (
        input  instr,
        output state_code
    );
endinterface

// File: rtl/instr_state_encoder.sv
// Maps an ARM instruction word to the ARMSIM control-unit starting state.
// One register stage: the code appears one clock after the instruction is sampled.
module instr_state_encoder (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_state_encoder_if.slave  bus
);

    localparam logic [2:0] OpDpReg   = 3'b000;
    localparam logic [2:0] OpDpImm   = 3'b001;
    localparam logic [2:0] OpLsImm   = 3'b010;
    localparam logic [2:0] OpLsReg   = 3'b011;
    localparam logic [2:0] OpBranch  = 3'b101;

    localparam logic [6:0] CodeBl      = 7'd40;
    localparam logic [6:0] CodeB       = 7'd42;
    localparam logic [6:0] CodeDpImm   = 7'd43;
    localparam logic [6:0] CodeDpReg   = 7'd44;
    localparam logic [6:0] CodeUnsupp  = 7'd0;

    localparam logic [6:0] BaseLsImmSt = 7'd4;
    localparam logic [6:0] BaseLsImmLd = 7'd22;
    localparam logic [6:0] BaseLsRegSt = 7'd11;
    localparam logic [6:0] BaseLsRegLd = 7'd29;
    localparam logic [6:0] BaseHwRegSt = 7'd52;
    localparam logic [6:0] BaseHwImmSt = 7'd45;
    localparam logic [6:0] BaseHwRegLd = 7'd70;
    localparam logic [6:0] BaseHwImmLd = 7'd63;

    logic [2:0] op;
    logic       p_bit;
    logic       u_bit;
    logic       w_bit;
    logic       l_bit;
    logic       hw_imm;
    logic       is_hw;
    logic [6:0] off_imm;
    logic [6:0] off_reg;
    logic [6:0] hw_base;
    logic [6:0] state_code_d;
    logic [6:0] state_code_q;

    assign op     = bus.instr[27:25];
    assign p_bit  = bus.instr[24];
    assign u_bit  = bus.instr[23];
    assign hw_imm = bus.instr[22];
    assign w_bit  = bus.instr[21];
    assign l_bit  = bus.instr[20];
    assign is_hw  = bus.instr[7] & bus.instr[4];

    // Bits outside the decoded fields are intentionally ignored.
    logic unused_instr;
    assign unused_instr = ^{bus.instr[31:28], bus.instr[19:8], bus.instr[6:5], bus.instr[3:0]};

    // Addressing-mode offset from the class base; immediate and register
    // forms share pre/post-index offsets but differ for offset-only (P1W0).
    always_comb begin
        off_imm = 7'd0;
        off_reg = 7'd0;
        if (!p_bit) begin
            off_imm = u_bit ? 7'd2 : 7'd0;
            off_reg = u_bit ? 7'd2 : 7'd0;
        end else if (w_bit) begin
            off_imm = u_bit ? 7'd6 : 7'd4;
            off_reg = u_bit ? 7'd6 : 7'd4;
        end else begin
            off_imm = u_bit ? 7'd17 : 7'd16;
            off_reg = u_bit ? 7'd8  : 7'd7;
        end
    end

    always_comb begin
        hw_base = BaseHwRegSt;
        case ({l_bit, hw_imm})
            2'b00:   hw_base = BaseHwRegSt;
            2'b01:   hw_base = BaseHwImmSt;
            2'b10:   hw_base = BaseHwRegLd;
            2'b11:   hw_base = BaseHwImmLd;
            default: hw_base = BaseHwRegSt;
        endcase
    end

    always_comb begin
        state_code_d = CodeUnsupp;
        case (op)
            OpBranch: state_code_d = p_bit ? CodeBl : CodeB;
            OpLsImm:  state_code_d = (l_bit ? BaseLsImmLd : BaseLsImmSt) + off_imm;
            OpLsReg:  state_code_d = (l_bit ? BaseLsRegLd : BaseLsRegSt) + off_reg;
            OpDpReg: begin
                if (is_hw) begin
                    state_code_d = hw_base + (hw_imm ? off_imm : off_reg);
                end else begin
                    state_code_d = CodeDpReg;
                end
            end
            OpDpImm:  state_code_d = CodeDpImm;
            default:  state_code_d = CodeUnsupp;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_code_q <= 7'd0;
        end else begin
            state_code_q <= state_code_d;
        end
    end

    assign bus.state_code = state_code_q;

endmodule

// File: tb/tb_instr_state_encoder.sv
// Self-checking bench for instr_state_encoder: directed rows with random or X
// filler bits, randomized instructions against a table-driven reference model.
module tb_instr_state_encoder;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [6:0] prev_code;

    instr_state_encoder_if bus ();

    instr_state_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed rows: value of the decoded fields, mask of those fields, code.
    logic [31:0] row_val [16] = '{
        32'h0400_0000, 32'h05A0_0000, 32'h0600_0000, 32'h0780_0000, 32'h0510_0000, 32'h07B0_0000,
        32'h0B00_0000, 32'h0A00_0000, 32'h0200_0000, 32'h0000_0000,
        32'h0040_0090, 32'h01E0_0090, 32'h0100_0090, 32'h0050_0090, 32'h01B0_0090, 32'h01D0_0090
    };
    logic [31:0] row_mask [16] = '{
        32'h0FB0_0000, 32'h0FB0_0000, 32'h0FB0_0000, 32'h0FB0_0000, 32'h0FB0_0000, 32'h0FB0_0000,
        32'h0F00_0000, 32'h0F00_0000, 32'h0E00_0000, 32'h0E00_0010,
        32'h0FF0_0090, 32'h0FF0_0090, 32'h0FF0_0090, 32'h0FF0_0090, 32'h0FF0_0090, 32'h0FF0_0090
    };
    logic [6:0] row_exp [16] = '{
        7'd4, 7'd10, 7'd11, 7'd19, 7'd38, 7'd35,
        7'd40, 7'd42, 7'd43, 7'd44,
        7'd45, 7'd51, 7'd59, 7'd63, 7'd76, 7'd80
    };

    // Reference tables, columns: P0U0, P0U1, P1U0W1, P1U1W1, P1U0W0, P1U1W0.
    int ls_imm [2][6] = '{'{4, 6, 8, 10, 20, 21}, '{22, 24, 26, 28, 38, 39}};
    int ls_reg [2][6] = '{'{11, 13, 15, 17, 18, 19}, '{29, 31, 33, 35, 36, 37}};
    int hw_tab [2][2][6] = '{
        '{'{52, 54, 56, 58, 59, 60}, '{45, 47, 49, 51, 61, 62}},
        '{'{70, 72, 74, 76, 77, 78}, '{63, 65, 67, 69, 79, 80}}
    };

    function automatic int mode_col(input logic [31:0] i);
        if (!i[24]) return i[23] ? 1 : 0;
        if (i[21])  return i[23] ? 3 : 2;
        return i[23] ? 5 : 4;
    endfunction

    function automatic logic [6:0] model_code(input logic [31:0] i);
        int col;
        int l;
        col = mode_col(i);
        l   = i[20] ? 1 : 0;
        case (i[27:25])
            3'b101: return i[24] ? 7'd40 : 7'd42;
            3'b010: return 7'(ls_imm[l][col]);
            3'b011: return 7'(ls_reg[l][col]);
            3'b000: begin
                if (i[7] && i[4]) return 7'(hw_tab[l][i[22] ? 1 : 0][col]);
                return 7'd44;
            end
            3'b001: return 7'd43;
            default: return 7'd0;
        endcase
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.instr = $urandom();
            #1;
            checks++;
            if (bus.state_code !== 7'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %0d want 0", c, bus.state_code);
            end
        end
        @(negedge clk);
        bus.instr = 32'h0800_0000;
        reset_n = 1'b1;
        @(negedge clk);
        bus.instr = 32'h0200_0000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.state_code !== 7'd43) begin
            errors++;
            $display("FAIL reset_release: got %0d want 43", bus.state_code);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.state_code !== 7'd0) begin
            errors++;
            $display("FAIL reset_async: got %0d want 0", bus.state_code);
        end
        @(negedge clk);
        bus.instr = 32'h0800_0000;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        prev_code = 7'd0;
    endtask

    task automatic test_word_byte();
        for (int r = 0; r < 6; r++) begin
            logic [31:0] v;
            v = ($urandom() & ~row_mask[r]) | row_val[r];
            @(negedge clk);
            bus.instr = v;
            #1;
            checks++;
            if (bus.state_code !== prev_code) begin
                errors++;
                $display("FAIL word_latency row %0d: got %0d want %0d", r, bus.state_code, prev_code);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.state_code !== row_exp[r]) begin
                errors++;
                $display("FAIL word_byte row %0d instr %h: got %0d want %0d", r, v, bus.state_code,
                         row_exp[r]);
            end
            prev_code = row_exp[r];
        end
    endtask

    task automatic test_branch_dp();
        for (int r = 6; r < 10; r++) begin
            logic [31:0] v;
            v = ($urandom() & ~row_mask[r]) | row_val[r];
            @(negedge clk);
            bus.instr = v;
            @(posedge clk);
            #1;
            checks++;
            if (bus.state_code !== row_exp[r]) begin
                errors++;
                $display("FAIL branch_dp row %0d instr %h: got %0d want %0d", r, v, bus.state_code,
                         row_exp[r]);
            end
            prev_code = row_exp[r];
        end
    endtask

    task automatic test_halfword();
        for (int r = 10; r < 16; r++) begin
            logic [31:0] v;
            v = ($urandom() & ~row_mask[r]) | row_val[r];
            @(negedge clk);
            bus.instr = v;
            @(posedge clk);
            #1;
            checks++;
            if (bus.state_code !== row_exp[r]) begin
                errors++;
                $display("FAIL halfword row %0d instr %h: got %0d want %0d", r, v, bus.state_code,
                         row_exp[r]);
            end
            prev_code = row_exp[r];
        end
    endtask

    task automatic test_x_robust();
        logic [31:0] xs;
        xs = 'x;
        for (int r = 0; r < 16; r++) begin
            logic [31:0] v;
            v = (xs & ~row_mask[r]) | row_val[r];
            @(negedge clk);
            bus.instr = v;
            @(posedge clk);
            #1;
            checks++;
            if (bus.state_code !== row_exp[r]) begin
                errors++;
                $display("FAIL x_robust row %0d: got %b want %0d", r, bus.state_code, row_exp[r]);
            end
            prev_code = row_exp[r];
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] v;
            logic [6:0]  exp;
            v = $urandom();
            // Bias half the draws toward the halfword class.
            if (n % 2 == 0) v = (v & ~32'h0E00_0090) | 32'h0000_0090;
            exp = model_code(v);
            @(negedge clk);
            bus.instr = v;
            #1;
            checks++;
            if (bus.state_code !== prev_code) begin
                errors++;
                $display("FAIL random_hold %0d: got %0d want %0d", n, bus.state_code, prev_code);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.state_code !== exp) begin
                errors++;
                $display("FAIL random %0d instr %h: got %0d want %0d", n, v, bus.state_code, exp);
            end
            prev_code = exp;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4] = '{32'h0200_0000, 32'h0400_0000, 32'h01D0_0090, 32'h0800_0000};
        logic [6:0]  want [4] = '{7'd43, 7'd4, 7'd80, 7'd0};
        @(negedge clk);
        bus.instr = seq[0];
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) bus.instr = seq[k + 1];
            #1;
            checks++;
            if (bus.state_code !== want[k]) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %0d want %0d", k, bus.state_code, want[k]);
            end
        end
        prev_code = want[3];
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        prev_code = 7'd0;
        reset_n   = 1'b0;
        bus.instr = 32'h0;
        test_reset();
        test_word_byte();
        test_branch_dp();
        test_halfword();
        test_x_robust();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
